// File: rtl/pixel_pkg.sv
// Shared widths, frame size, opcode and payload/state types for the pixel output path.
package pixel_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned FRAME_PIXELS = 304200;

  localparam logic [4:0] OP_GP = 5'd10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pix_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } flush_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is read straight from the array, no fall-through.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned PW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/pixel_out_buffer.sv
// Buffers GP pixel stores from MEM as {address, pixel} pairs and streams them to the image sink;
// owns the frame address counter, the flush sequence, the done pulses and the sticky overflow flag.
module pixel_out_buffer
  import pixel_pkg::DATA_W, pixel_pkg::ADDR_W, pixel_pkg::pix_entry_t,
         pixel_pkg::flush_state_t, pixel_pkg::RUN, pixel_pkg::DRAIN, pixel_pkg::DONE;
#(
  parameter int unsigned FRAME_PIXELS = pixel_pkg::FRAME_PIXELS,
  parameter int unsigned DEPTH        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PixWrEn,
  input  logic [DATA_W-1:0] PixData,
  input  logic              FlushReq,
  input  logic              OutReady,
  output logic              OutValid,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutAddr,
  output logic              Stall,
  output logic              FrameDone,
  output logic              FlushDone,
  output logic              Overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  pix_entry_t       wr_entry, rd_entry;
  logic             push, pop, full, empty;
  logic [PTR_W-1:0] count;

  flush_state_t      state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              frame_done_q, frame_done_d;
  logic              flush_done_q, flush_done_d;
  logic              overflow_q, overflow_d;

  assign Stall    = full || (state_q != RUN);
  assign push     = PixWrEn && !Stall;
  assign OutValid = !empty;
  assign pop      = OutValid && OutReady;
  assign wr_entry = '{addr: wr_addr_q, data: PixData};

  assign OutData   = rd_entry.data;
  assign OutAddr   = rd_entry.addr;
  assign FrameDone = frame_done_q;
  assign FlushDone = flush_done_q;
  assign Overflow  = overflow_q;

  sync_fifo #(
    .WIDTH ($bits(pix_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Flush sequencing, frame address counter and status flags.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    flush_done_d = 1'b0;
    frame_done_d = pop && (rd_entry.addr == ADDR_W'(FRAME_PIXELS - 1));
    overflow_d   = overflow_q || (PixWrEn && Stall);

    if (push) begin
      wr_addr_d = (wr_addr_q == ADDR_W'(FRAME_PIXELS - 1)) ? '0 : wr_addr_q + ADDR_W'(1);
    end

    case (state_q)
      RUN: begin
        if (FlushReq) state_d = DRAIN;
      end
      DRAIN: begin
        if (count == '0) begin
          state_d      = DONE;
          flush_done_d = 1'b1;
        end
      end
      DONE: begin
        state_d   = RUN;
        wr_addr_d = '0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
      flush_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= frame_done_d;
      flush_done_q <= flush_done_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pixel_out_buffer.sv
// Bench for pixel_out_buffer: directed vectors and sequences plus a randomized run against a queue model.
// The frame length is shortened so that frame wrap is reachable in a short run.
module tb_pixel_out_buffer;
  import pixel_pkg::*;

  localparam int unsigned FP  = 40;
  localparam int unsigned DEP = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              PixWrEn = 1'b0;
  logic [DATA_W-1:0] PixData = '0;
  logic              FlushReq = 1'b0;
  logic              OutReady = 1'b0;
  logic              OutValid;
  logic [DATA_W-1:0] OutData;
  logic [ADDR_W-1:0] OutAddr;
  logic              Stall, FrameDone, FlushDone, Overflow;

  always #5 clk = ~clk;

  pixel_out_buffer #(.FRAME_PIXELS(FP), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .PixWrEn(PixWrEn), .PixData(PixData), .FlushReq(FlushReq),
    .OutReady(OutReady), .OutValid(OutValid), .OutData(OutData), .OutAddr(OutAddr),
    .Stall(Stall), .FrameDone(FrameDone), .FlushDone(FlushDone), .Overflow(Overflow)
  );

  // Reference model: queue of pending entries plus frame counter and flush phase (0 run, 1 drain, 2 done).
  pix_entry_t  q[$];
  int unsigned m_waddr;
  int          m_phase;
  bit          m_ovf, m_frd, m_fld;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("OutValid", 32'(OutValid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("OutData", 32'(OutData), 32'(q[0].data));
      chk("OutAddr", 32'(OutAddr), 32'(q[0].addr));
    end
    chk("Stall", 32'(Stall), 32'((q.size() == DEP) || (m_phase != 0)));
    chk("FrameDone", 32'(FrameDone), 32'(m_frd));
    chk("FlushDone", 32'(FlushDone), 32'(m_fld));
    chk("Overflow", 32'(Overflow), 32'(m_ovf));
  endtask

  // One clock: apply inputs, compare against the model, advance the model, cross the edge.
  task automatic step(input bit we, input logic [DATA_W-1:0] d, input bit rdy, input bit fr);
    bit         stall, was_empty;
    pix_entry_t e;
    PixWrEn = we; PixData = d; OutReady = rdy; FlushReq = fr;
    #1;
    check_model();
    stall     = (q.size() == DEP) || (m_phase != 0);
    was_empty = (q.size() == 0);
    m_frd = 1'b0;
    m_fld = 1'b0;
    if (we && stall) m_ovf = 1'b1;
    if (!was_empty && rdy) begin
      e = q.pop_front();
      m_frd = (e.addr == ADDR_W'(FP - 1));
    end
    if (we && !stall) begin
      e.addr = ADDR_W'(m_waddr);
      e.data = d;
      q.push_back(e);
      m_waddr = (m_waddr + 1) % FP;
    end
    case (m_phase)
      0: if (fr) m_phase = 1;
      1: if (was_empty) begin m_phase = 2; m_fld = 1'b1; end
      default: begin m_phase = 0; m_waddr = 0; end
    endcase
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; PixWrEn = 1'b0; FlushReq = 1'b0; OutReady = 1'b0;
    #3;
    q.delete();
    m_waddr = 0; m_phase = 0; m_ovf = 1'b0; m_frd = 1'b0; m_fld = 1'b0;
    check_model();
    chk("rst OutData", 32'(OutData), 32'h0);
    chk("rst OutAddr", 32'(OutAddr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  typedef struct {
    bit                we;
    logic [DATA_W-1:0] d;
    bit                rdy;
    bit                ev;
    logic [DATA_W-1:0] ed;
    logic [ADDR_W-1:0] ea;
  } vec_t;

  vec_t tv[5];

  initial begin
    int pops, nfd, guard, p_rdy;
    bit seen;

    // 1: three pushes with the sink always ready; one-cycle latency, in-order addresses.
    tv[0] = '{we: 1, d: 8'h11, rdy: 1, ev: 0, ed: 8'h00, ea: 19'd0};
    tv[1] = '{we: 1, d: 8'h22, rdy: 1, ev: 1, ed: 8'h11, ea: 19'd0};
    tv[2] = '{we: 1, d: 8'h33, rdy: 1, ev: 1, ed: 8'h22, ea: 19'd1};
    tv[3] = '{we: 0, d: 8'h00, rdy: 1, ev: 1, ed: 8'h33, ea: 19'd2};
    tv[4] = '{we: 0, d: 8'h00, rdy: 1, ev: 0, ed: 8'h00, ea: 19'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("t1 OutValid", 32'(OutValid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk("t1 OutData", 32'(OutData), 32'(tv[i].ed));
        chk("t1 OutAddr", 32'(OutAddr), 32'(tv[i].ea));
      end
      step(tv[i].we, tv[i].d, tv[i].rdy, 1'b0);
    end

    // 2: fill with the sink stalled, overflow on the 17th push, one pop releases Stall.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(i + 8'h40), 1'b0, 1'b0);
    chk("t2 Stall full", 32'(Stall), 32'h1);
    chk("t2 Overflow pre", 32'(Overflow), 32'h0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("t2 Overflow", 32'(Overflow), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2 Stall after pop", 32'(Stall), 32'h0);
    chk("t2 head", 32'(OutData), 32'h41);

    // 5: full FIFO with push and pop together; push refused, 15 entries remain.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t5 Overflow", 32'(Overflow), 32'h1);
    chk("t5 Stall", 32'(Stall), 32'h0);
    pops = 0;
    for (int i = 0; i < 20 && OutValid; i++) begin
      pops++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t5 count", 32'(pops), 32'd15);

    // 3: one frame plus one pixel; a single FrameDone, and the next pixel restarts at 0.
    do_reset();
    nfd = 0;
    for (int i = 0; i < FP + 1; i++) begin
      step(1'b1, DATA_W'(i * 3), 1'b1, 1'b0);
      if (FrameDone) nfd++;
    end
    chk("t3 wrap addr", 32'(OutAddr), 32'h0);
    chk("t3 wrap data", 32'(OutData), 32'(DATA_W'(FP * 3)));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (FrameDone) nfd++;
    end
    chk("t3 FrameDone count", 32'(nfd), 32'd1);

    // 4: flush with five queued entries.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DATA_W'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t4 Stall drain", 32'(Stall), 32'h1);
    pops = 1;
    seen = 1'b0;
    for (guard = 0; guard < 30; guard++) begin
      if (FlushDone) begin seen = 1'b1; break; end
      if (OutValid) pops++;
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t4 FlushDone seen", 32'(seen), 32'h1);
    chk("t4 pops", 32'(pops), 32'd5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("t4 restart addr", 32'(OutAddr), 32'h0);
    chk("t4 restart data", 32'(OutData), 32'h5A);

    // 6: reset in the middle of a drain discards everything.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, DATA_W'(i + 1), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("t6 restart addr", 32'(OutAddr), 32'h0);
    chk("t6 restart valid", 32'(OutValid), 32'h1);

    // Randomized traffic with varying sink readiness, occasional flushes and resets.
    do_reset();
    p_rdy = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) p_rdy = (($urandom % 3) == 0) ? 15 : (($urandom % 2) == 0) ? 55 : 95;
      if (($urandom % 1500) == 0) do_reset();
      step(($urandom % 4) != 0, DATA_W'($urandom), int'($urandom % 100) < p_rdy,
           ($urandom % 150) == 0);
    end
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
